a2d_arbiter: RTL and testbench
==============================

# a2d_arbiter

Shares the single A2D converter interface (strt_cnv / chnnl / cnv_cmplt / res) between several requesters, e.g. motion_cntrl IR sampling and a battery/housekeeping monitor. Round-robin arbitration, one conversion in flight at a time, channel held stable for the full conversion, result returned with a per-requester done pulse. Sits between the requesters and the A2D interface block.

## Interface
- NREQ, 2, number of requesters (2..4)
- RES_W, 12, conversion result width
- TIMEOUT_CYC, 1024, watchdog limit in clk cycles (used only with the timeout feature)

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester conversion request, level, held until its done pulse
- req_chnnl  in  3*NREQ  flattened channel selects; requester i uses bits [3i+2:3i]; stable while req[i] high
- done  out  NREQ  one-cycle pulse to the granted requester when its result is valid
- err  out  1  high with done when the conversion timed out (0 when the timeout feature is compiled out)
- res_out  out  RES_W  registered result, valid from the done cycle until the next done
- busy  out  1  high in every state except IDLE
- strt_cnv  out  1  one-cycle start to the A2D interface
- chnnl  out  3  registered channel to the A2D interface
- cnv_cmplt  in  1  conversion-complete pulse from the A2D interface
- res  in  RES_W  A2D result, valid while cnv_cmplt is high

## Operation
- States: IDLE, START, WAIT, RECOVER.
- IDLE: with any req bit high, pick the winner by round-robin, searching from last_gnt+1 upward with wrap. Register gnt, last_gnt <= winner, chnnl <= req_chnnl[winner]. Go to START.
- START: strt_cnv=1 for exactly this cycle. Go to WAIT.
- WAIT: on cnv_cmplt, res_out <= res, done[gnt] <= 1, err <= 0. Go to RECOVER.
- RECOVER: one cycle with no arbitration; requester drops req while done is high. Go to IDLE.
- chnnl holds from START through RECOVER and is never changed while a conversion is in flight.
- A requester that keeps req high after RECOVER is treated as a new request and competes normally.
- cnv_cmplt outside WAIT is ignored: no state change, res_out unchanged.
- Request bits for non-granted requesters may change at any time with no effect until IDLE.
- Reset (asynchronous, any state): state=IDLE, last_gnt=NREQ-1 so requester 0 has first priority, gnt=0, chnnl=0, strt_cnv=0, done=0, err=0, res_out=0, busy=0, timeout counter=0.

## Timing
- Request high before edge 1 (state IDLE): START after edge 1, strt_cnv high in cycle 1, WAIT from edge 2.
- cnv_cmplt high in cycle k: done/res_out/err valid in cycle k+1 (RECOVER), IDLE at edge k+2.
- Minimum request-to-request spacing is 3 cycles plus the conversion time.
- All outputs are registered. strt_cnv and done are single-cycle pulses.

## Configuration
- A2D_ARB_TIMEOUT_EN defined: a counter clears on entry to WAIT and increments each WAIT cycle. If it reaches TIMEOUT_CYC-1 with no cnv_cmplt, go to RECOVER with done[gnt]=1, err=1 and res_out=0. If cnv_cmplt arrives in the same cycle the limit is reached, cnv_cmplt wins and err=0.
- A2D_ARB_TIMEOUT_EN not defined: no counter. WAIT lasts until cnv_cmplt indefinitely, and err is tied to 0.

## Test plan
- Single request: req=2'b01, req_chnnl[2:0]=3'b100, cnv_cmplt+res=12'hA5C 20 cycles after strt_cnv -> chnnl=4 from START on, one strt_cnv pulse, done=2'b01 for one cycle, res_out=12'hA5C, busy drops after RECOVER.
- Contention after reset: req=2'b11 with channels 1 and 7 -> requester 0 (ch 1) first, then requester 1 (ch 7); done pulses in order 01 then 10.
- Fairness: both requesters hold req high for 6 conversions -> grants alternate 0,1,0,1,0,1 with no starvation.
- Stray and late events: cnv_cmplt pulsed in IDLE and START -> no done and res_out unchanged. Change req_chnnl[0] during WAIT -> chnnl output unchanged.
- Reset mid-WAIT: assert rst_n=0 two cycles after strt_cnv -> all outputs 0 immediately. After release with req=2'b10, requester 1 is granted and the first conversion completes normally.
- Timeout (A2D_ARB_TIMEOUT_EN, TIMEOUT_CYC=16): never return cnv_cmplt -> done and err high 16 cycles after entering WAIT, res_out=0. Returning cnv_cmplt on the limit cycle -> err=0 and res_out=res.

Source files
------------

// File: rtl/a2d_arbiter.sv
// rtl/a2d_arbiter.sv - round-robin arbiter sharing one A2D converter between NREQ requesters
//
// One conversion in flight at a time. The channel is latched at grant and held
// from START through RECOVER. Each result is returned with a one-cycle done
// pulse to the requester that was granted.
//
// Optional feature: define A2D_ARB_TIMEOUT_EN to add a WAIT watchdog. When
// TIMEOUT_CYC WAIT cycles pass with no cnv_cmplt, the conversion is abandoned
// with done[gnt]=1, err=1 and res_out=0. Without the macro, err is always 0.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   req[NREQ]           level requests, held until the matching done pulse
//   req_chnnl[3*NREQ]   channel select, requester i on bits [3i+2:3i]
//   done[NREQ]          one-cycle completion pulse to the granted requester
//   err                 high with done on a watchdog expiry
//   res_out[RES_W]      registered result, held until the next done
//   busy                high whenever the FSM is not in IDLE
//   strt_cnv, chnnl     start pulse and held channel to the A2D interface
//   cnv_cmplt, res      completion pulse and result from the A2D interface
module a2d_arbiter #(
  parameter int NREQ        = 2,
  parameter int RES_W       = 12,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [3*NREQ-1:0]  req_chnnl,
  output logic [NREQ-1:0]    done,
  output logic               err,
  output logic [RES_W-1:0]   res_out,
  output logic               busy,
  output logic               strt_cnv,
  output logic [2:0]         chnnl,
  input  logic               cnv_cmplt,
  input  logic [RES_W-1:0]   res
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 4 || TIMEOUT_CYC < 2) begin : g_bad_params
    $error("a2d_arbiter: NREQ must be 2..4 and TIMEOUT_CYC at least 2");
  end

  typedef enum logic [1:0] {IDLE, START, WAIT, RECOVER} state_t;

  state_t           state_q, state_d;
  logic [GW-1:0]    gnt_q, gnt_d;
  logic [GW-1:0]    last_gnt_q, last_gnt_d;
  logic [2:0]       chnnl_q, chnnl_d;
  logic             strt_q, strt_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic             err_q, err_d;
  logic [RES_W-1:0] res_q, res_d;
  logic             busy_q, busy_d;
  logic             to_hit;

`ifdef A2D_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  logic [TW-1:0] to_cnt_q, to_cnt_d;

  // Counter is zero during START so it reads 0 in the first WAIT cycle.
  assign to_cnt_d = (state_q == WAIT) ? to_cnt_q + 1'b1 : '0;
  assign to_hit   = (state_q == WAIT) && (to_cnt_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) to_cnt_q <= '0;
    else        to_cnt_q <= to_cnt_d;
  end
`else
  assign to_hit = 1'b0;
`endif

  // Round-robin search starting just after the previous winner, with wrap.
  logic          win_found;
  logic [GW-1:0] win;
  int            idx;

  always_comb begin
    win_found = 1'b0;
    win       = '0;
    idx       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_gnt_q) + k) % NREQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win       = GW'(idx);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    chnnl_d    = chnnl_q;
    strt_d     = 1'b0;
    done_d     = '0;
    err_d      = 1'b0;
    res_d      = res_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_d      = win;
          last_gnt_d = win;
          chnnl_d    = req_chnnl[3*win +: 3];
          strt_d     = 1'b1;
          state_d    = START;
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        // A completion on the limit cycle takes precedence over the watchdog.
        if (cnv_cmplt) begin
          res_d         = res;
          done_d[gnt_q] = 1'b1;
          state_d       = RECOVER;
        end else if (to_hit) begin
          res_d         = '0;
          done_d[gnt_q] = 1'b1;
          err_d         = 1'b1;
          state_d       = RECOVER;
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      last_gnt_q <= GW'(NREQ - 1);
      chnnl_q    <= '0;
      strt_q     <= 1'b0;
      done_q     <= '0;
      err_q      <= 1'b0;
      res_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      chnnl_q    <= chnnl_d;
      strt_q     <= strt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      res_q      <= res_d;
      busy_q     <= busy_d;
    end
  end

  assign done     = done_q;
  assign err      = err_q;
  assign res_out  = res_q;
  assign busy     = busy_q;
  assign strt_cnv = strt_q;
  assign chnnl    = chnnl_q;

endmodule

// File: tb/tb_a2d_arbiter.sv
// tb/tb_a2d_arbiter.sv - scoreboard bench for a2d_arbiter
module tb_a2d_arbiter;

  localparam int NREQ  = 2;
  localparam int RES_W = 12;
`ifdef A2D_ARB_TIMEOUT_EN
  localparam int TO_CYC   = 16;
  localparam int LONG_DLY = 12;
`else
  localparam int TO_CYC   = 1024;
  localparam int LONG_DLY = 20;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [3*NREQ-1:0] req_chnnl;
  logic [NREQ-1:0]   done;
  logic              err;
  logic [RES_W-1:0]  res_out;
  logic              busy;
  logic              strt_cnv;
  logic [2:0]        chnnl;
  logic              cnv_cmplt;
  logic [RES_W-1:0]  res;

  a2d_arbiter #(.NREQ(NREQ), .RES_W(RES_W), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_chnnl(req_chnnl),
    .done(done), .err(err), .res_out(res_out), .busy(busy),
    .strt_cnv(strt_cnv), .chnnl(chnnl), .cnv_cmplt(cnv_cmplt), .res(res)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NREQ-1:0]  done;
    logic [RES_W-1:0] res;
    logic             err;
    logic [2:0]       ch;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected completion.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n === 1'b1 && done !== '0) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'h0);
      end else begin
        e = sb.pop_front();
        chk("done_vec", 32'(done), 32'(e.done));
        chk("res_out", 32'(res_out), 32'(e.res));
        chk("err", 32'(err), 32'(e.err));
        chk("chnnl_at_done", 32'(chnnl), 32'(e.ch));
      end
    end
  end

  task automatic wait_start(input logic [2:0] exp_ch, input string tag);
    int n = 0;
    while (strt_cnv !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_strt"}, 32'(strt_cnv), 32'h1);
    chk({tag, "_chnnl"}, 32'(chnnl), 32'(exp_ch));
  endtask

  // Called on the START negedge; returns on the RECOVER negedge.
  task automatic complete(input logic [NREQ-1:0] gnt_oh, input logic [2:0] ch,
                          input logic [RES_W-1:0] r, input int dly, input logic drop);
    exp_t e;
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      if (i == 0) chk("strt_width", 32'(strt_cnv), 32'h0);
      chk("chnnl_hold", 32'(chnnl), 32'(ch));
    end
    e.done = gnt_oh; e.res = r; e.err = 1'b0; e.ch = ch;
    sb.push_back(e);
    cnv_cmplt = 1'b1;
    res       = r;
    @(negedge clk);
    cnv_cmplt = 1'b0;
    res       = '0;
    chk("busy_recover", 32'(busy), 32'h1);
    if (drop) req = req & ~gnt_oh;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req = '0; req_chnnl = '0; cnv_cmplt = 1'b0; res = '0;
    repeat (2) @(negedge clk);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_res", 32'(res_out), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_strt", 32'(strt_cnv), 32'h0);
    chk("rst_chnnl", 32'(chnnl), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request, channel 4
    req_chnnl = {3'd0, 3'd4};
    req = 2'b01;
    wait_start(3'd4, "single");
    complete(2'b01, 3'd4, 12'hA5C, LONG_DLY, 1'b1);
    @(negedge clk);
    chk("single_busy_idle", 32'(busy), 32'h0);
    chk("single_res_hold", 32'(res_out), 32'hA5C);

    // Contention straight after reset: requester 0 wins first
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req_chnnl = {3'd7, 3'd1};
    req = 2'b11;
    wait_start(3'd1, "cont0");
    complete(2'b01, 3'd1, 12'h111, 5, 1'b1);
    wait_start(3'd7, "cont1");
    complete(2'b10, 3'd7, 12'h222, 3, 1'b1);

    // Fairness: both held high, grants alternate 0,1,0,1,0,1
    req = 2'b11;
    for (int i = 0; i < 6; i++) begin
      wait_start((i % 2) ? 3'd7 : 3'd1, "fair");
      complete((i % 2) ? 2'b10 : 2'b01, (i % 2) ? 3'd7 : 3'd1,
               12'h300 + 12'(i), 4, 1'b0);
    end
    req = 2'b00;
    @(negedge clk);
    chk("fair_busy_idle", 32'(busy), 32'h0);

    // Stray cnv_cmplt in IDLE and in START
    cnv_cmplt = 1'b1; res = 12'hFFF;
    @(negedge clk);
    cnv_cmplt = 1'b0; res = '0;
    chk("stray_idle_res", 32'(res_out), 32'h305);
    chk("stray_idle_busy", 32'(busy), 32'h0);
    req_chnnl = {3'd7, 3'd2};
    req = 2'b01;
    wait_start(3'd2, "stray");
    cnv_cmplt = 1'b1; res = 12'hEEE;
    @(negedge clk);
    cnv_cmplt = 1'b0; res = '0;
    chk("stray_start_res", 32'(res_out), 32'h305);
    chk("stray_start_busy", 32'(busy), 32'h1);
    req_chnnl[2:0] = 3'd5;
    complete(2'b01, 3'd2, 12'hABC, 3, 1'b1);

    // Reset two cycles after strt_cnv, then requester 1 alone
    @(negedge clk);
    req_chnnl = {3'd5, 3'd3};
    req = 2'b01;
    wait_start(3'd3, "rstw");
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstw_done", 32'(done), 32'h0);
    chk("rstw_err", 32'(err), 32'h0);
    chk("rstw_res", 32'(res_out), 32'h0);
    chk("rstw_busy", 32'(busy), 32'h0);
    chk("rstw_strt", 32'(strt_cnv), 32'h0);
    chk("rstw_chnnl", 32'(chnnl), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    req = 2'b10;
    wait_start(3'd5, "rstw_r1");
    complete(2'b10, 3'd5, 12'h5A5, 6, 1'b1);
    @(negedge clk);
    chk("rstw_busy_idle", 32'(busy), 32'h0);

`ifdef A2D_ARB_TIMEOUT_EN
    begin
      exp_t e;
      int   n;
      req_chnnl = {3'd0, 3'd6};
      req = 2'b01;
      wait_start(3'd6, "to");
      e.done = 2'b01; e.res = '0; e.err = 1'b1; e.ch = 3'd6;
      sb.push_back(e);
      n = 0;
      while (done === '0 && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("to_latency", 32'(n), 32'd17);
      req = 2'b00;
      @(negedge clk);
      req = 2'b01;
      wait_start(3'd6, "to_lim");
      complete(2'b01, 3'd6, 12'hC3C, 16, 1'b1);
    end
`endif

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
